// File: rtl/iob_ram_2p_fifo_ctrl.sv
// rtl/iob_ram_2p_fifo_ctrl.sv - FIFO controller driving an external two-port RAM
// Optional sticky overflow/underflow flags are built when IOB_RAM_2P_FIFO_CTRL_ERR_EN is defined.
module iob_ram_2p_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
  input  logic              err_clr_i,
  output logic              overflow_o,
  output logic              underflow_o,
`endif
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] LEVEL_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_empty;
  logic              r_valid;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [ADDR_W:0]   w_level_nxt;

  assign w_push_ok   = w_en_i & ~r_full;
  assign w_pop_ok    = r_en_i & ~r_empty;
  assign w_level_nxt = r_level + (ADDR_W+1)'(w_push_ok) - (ADDR_W+1)'(w_pop_ok);

  // Flags come from the next level so they line up with level_o every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + ADDR_W'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LEVEL_FULL);
      r_empty <= (w_level_nxt == '0);
      r_valid <= w_pop_ok;
    end
  end

  assign w_full_o         = r_full;
  assign r_empty_o        = r_empty;
  assign level_o          = r_level;
  assign r_valid_o        = r_valid;
  assign r_data_o         = ext_mem_r_data_i;

  assign ext_mem_w_en_o   = w_push_ok;
  assign ext_mem_w_addr_o = r_wptr;
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_pop_ok;
  assign ext_mem_r_addr_o = r_rptr;

`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_en_i & r_full)        r_overflow <= 1'b1;
      else if (err_clr_i)         r_overflow <= 1'b0;
      if (r_en_i & r_empty)       r_underflow <= 1'b1;
      else if (err_clr_i)         r_underflow <= 1'b0;
    end
  end

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_iob_ram_2p_fifo_ctrl.sv
// tb/tb_iob_ram_2p_fifo_ctrl.sv - self-checking bench for iob_ram_2p_fifo_ctrl with queue model and RAM model
module tb_iob_ram_2p_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              w_en_i = 1'b0;
  logic [DATA_W-1:0] w_data_i = '0;
  logic              w_full_o;
  logic              r_en_i = 1'b0;
  logic [DATA_W-1:0] r_data_o;
  logic              r_valid_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              ext_mem_w_en_o;
  logic [ADDR_W-1:0] ext_mem_w_addr_o;
  logic [DATA_W-1:0] ext_mem_w_data_o;
  logic              ext_mem_r_en_o;
  logic [ADDR_W-1:0] ext_mem_r_addr_o;
  logic [DATA_W-1:0] ext_mem_r_data_i;
  logic              err_clr_i = 1'b0;
`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
  logic              overflow_o;
  logic              underflow_o;
`endif

  int tests = 0;
  int fails = 0;

  iob_ram_2p_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
    .err_clr_i        (err_clr_i),
    .overflow_o       (overflow_o),
    .underflow_o      (underflow_o),
`endif
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .w_en_i           (w_en_i),
    .w_data_i         (w_data_i),
    .w_full_o         (w_full_o),
    .r_en_i           (r_en_i),
    .r_data_o         (r_data_o),
    .r_valid_o        (r_valid_o),
    .r_empty_o        (r_empty_o),
    .level_o          (level_o),
    .ext_mem_w_en_o   (ext_mem_w_en_o),
    .ext_mem_w_addr_o (ext_mem_w_addr_o),
    .ext_mem_w_data_o (ext_mem_w_data_o),
    .ext_mem_r_en_o   (ext_mem_r_en_o),
    .ext_mem_r_addr_o (ext_mem_r_addr_o),
    .ext_mem_r_data_i (ext_mem_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // External two-port RAM, 1-cycle read latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk_i) begin
    if (ext_mem_w_en_o) ram[ext_mem_w_addr_o] <= ext_mem_w_data_o;
    if (ext_mem_r_en_o) ext_mem_r_data_i <= ram[ext_mem_r_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of stored words plus op counters
  logic [DATA_W-1:0] m_q[$];
  int                m_wcnt = 0;
  int                m_rcnt = 0;
  bit                m_valid = 0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                m_ovf = 0;
  bit                m_unf = 0;
  bit                m_init = 0;

  always @(negedge clk_i) begin
    bit full, empty, push_ok, pop_ok;
    full    = (m_q.size() == DEPTH);
    empty   = (m_q.size() == 0);
    push_ok = w_en_i && !full;
    pop_ok  = r_en_i && !empty;
    if (m_init) begin
      chk("level", 32'(level_o), 32'(m_q.size()));
      chk("full", 32'(w_full_o), 32'(full));
      chk("empty", 32'(r_empty_o), 32'(empty));
      chk("r_valid", 32'(r_valid_o), 32'(m_valid));
      if (m_valid) chk("r_data", 32'(r_data_o), 32'(m_rdata));
      chk("ext_w_en", 32'(ext_mem_w_en_o), 32'(push_ok));
      chk("ext_w_addr", 32'(ext_mem_w_addr_o), 32'(m_wcnt % DEPTH));
      chk("ext_w_data", 32'(ext_mem_w_data_o), 32'(w_data_i));
      chk("ext_r_en", 32'(ext_mem_r_en_o), 32'(pop_ok));
      chk("ext_r_addr", 32'(ext_mem_r_addr_o), 32'(m_rcnt % DEPTH));
`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("underflow", 32'(underflow_o), 32'(m_unf));
`endif
    end
    if (rst_i) begin
      m_q.delete();
      m_wcnt  = 0;
      m_rcnt  = 0;
      m_valid = 0;
      m_ovf   = 0;
      m_unf   = 0;
      m_init  = 1;
    end else begin
      if (pop_ok) begin
        m_rdata = m_q.pop_front();
        m_rcnt++;
      end
      m_valid = pop_ok;
      if (push_ok) begin
        m_q.push_back(w_data_i);
        m_wcnt++;
      end
      if (w_en_i && full)   m_ovf = 1;
      else if (err_clr_i)   m_ovf = 0;
      if (r_en_i && empty)  m_unf = 1;
      else if (err_clr_i)   m_unf = 0;
    end
  end

  task automatic set_in(input logic we, input logic [DATA_W-1:0] wd, input logic re,
                        input logic rs, input logic ec);
    w_en_i    = we;
    w_data_i  = wd;
    r_en_i    = re;
    rst_i     = rs;
    err_clr_i = ec;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // 1. reset
    set_in(0, 0, 0, 1, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0);
    #1;
    chk("rst_empty", 32'(r_empty_o), 32'd1);
    chk("rst_full", 32'(w_full_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_valid", 32'(r_valid_o), 32'd0);
    chk("rst_w_en", 32'(ext_mem_w_en_o), 32'd0);
    chk("rst_r_en", 32'(ext_mem_r_en_o), 32'd0);
    tick();

    // 2. fill with 32..47, then push while full
    for (int i = 0; i < 16; i++) begin
      set_in(1, 8'(32 + i), 0, 0, 0);
      #1;
      chk("fill_addr", 32'(ext_mem_w_addr_o), 32'(i));
      tick();
    end
    chk("fill_level", 32'(level_o), 32'd16);
    chk("fill_full", 32'(w_full_o), 32'd1);
    set_in(1, 8'd99, 0, 0, 0);
    #1;
    chk("push_full_w_en", 32'(ext_mem_w_en_o), 32'd0);
    tick();
    chk("push_full_level", 32'(level_o), 32'd16);

    // 3. drain, then pop while empty
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, 1, 0, 0);
      tick();
      chk("drain_valid", 32'(r_valid_o), 32'd1);
      chk("drain_data", 32'(r_data_o), 32'(32 + i));
    end
    chk("drain_empty", 32'(r_empty_o), 32'd1);
    set_in(0, 0, 1, 0, 0);
    #1;
    chk("pop_empty_r_en", 32'(ext_mem_r_en_o), 32'd0);
    tick();
    chk("pop_empty_valid", 32'(r_valid_o), 32'd0);

    // 4. level 5 then simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) begin
      set_in(1, 8'(200 + i), 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1, 8'(100 + i), 1, 0, 0);
      tick();
      chk("stream_level", 32'(level_o), 32'd5);
      if (i == 0) chk("stream_first", 32'(r_data_o), 32'd200);
      if (i == 5) chk("stream_sixth", 32'(r_data_o), 32'd100);
    end

    // 5. reset mid-stream at level 7 with a pop issued
    for (int i = 0; i < 2; i++) begin
      set_in(1, 8'(150 + i), 0, 0, 0);
      tick();
    end
    chk("pre_rst_level", 32'(level_o), 32'd7);
    set_in(0, 0, 1, 1, 0);
    tick();
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_empty", 32'(r_empty_o), 32'd1);
    chk("mid_rst_valid", 32'(r_valid_o), 32'd0);

`ifdef IOB_RAM_2P_FIFO_CTRL_ERR_EN
    // 6. sticky error flags
    set_in(0, 0, 1, 0, 0);
    tick();
    chk("unf_set", 32'(underflow_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      set_in(1, 8'(i), 0, 0, 0);
      tick();
    end
    chk("ovf_pre", 32'(overflow_o), 32'd0);
    set_in(1, 8'd77, 0, 0, 0);
    tick();
    chk("ovf_set", 32'(overflow_o), 32'd1);
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("ovf_hold", 32'(overflow_o), 32'd1);
    chk("unf_hold", 32'(underflow_o), 32'd1);
    set_in(0, 0, 0, 0, 1);
    tick();
    chk("ovf_clr", 32'(overflow_o), 32'd0);
    chk("unf_clr", 32'(underflow_o), 32'd0);
    set_in(1, 8'd78, 0, 0, 1);
    tick();
    chk("ovf_set_wins", 32'(overflow_o), 32'd1);
`endif

    // Random phase: alternate push-heavy and pop-heavy windows
    for (int k = 0; k < 1200; k++) begin
      int bias;
      bias = ((k / 100) % 2 == 0) ? 75 : 25;
      set_in(logic'($urandom_range(0, 99) < bias),
             DATA_W'($urandom),
             logic'($urandom_range(0, 99) >= bias),
             logic'($urandom_range(0, 299) == 0),
             logic'($urandom_range(0, 15) == 0));
      tick();
    end

    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
